i2c_cfg_sequencer: RTL and testbench

Parametrised I2C register-configuration sequencer with its own bit-level I2C master. It walks an external configuration table of {slave address, sub-address, data} entries and writes each entry over one open-drain I2C bus. It can be re-triggered, retries NACKed writes, stops early on an end marker, and reports busy/done/error status. It sits between the top level and the on-board codec/video-decoder I2C bus, and supersedes the fixed audio/video setup path.

---
 rtl/i2c_cfg_sequencer.sv | 174 +++++++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer
//   Walks an external table of {slave addr, sub-address, data} entries and
//   writes each one over an open-drain I2C bus using a built-in bit-level
//   master. NACKed writes are retried up to MAX_RETRY times. A slave address
//   of 8'hFF ends the sequence early.
//
//   Optional build macro: I2C_CFG_CLK_STRETCH_EN
//     defined     : the quarter counter freezes while SCL is released but
//                   still reads low (slave clock stretching).
//     not defined : I2C_SCLK is never sampled; timing is purely counter based.
//
// Ports
//   CLOCK_50    in   system clock (rising edge)
//   iRST_N      in   asynchronous active-low reset
//   iSTART      in   start request, honoured only in IDLE/DONE/ERROR
//   oLUT_INDEX  out  current table index
//   iLUT_DATA   in   {addr, sub, data}, combinational function of oLUT_INDEX
//   I2C_SCLK    io   open-drain SCL (0 or 'z')
//   I2C_SDAT    io   open-drain SDA (0 or 'z')
//   oBUSY       out  sequence in progress
//   oDONE       out  sequence finished cleanly (sticky until next start)
//   oERR        out  retry budget exhausted (sticky); oLUT_INDEX = failing entry
module i2c_cfg_sequencer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int I2C_FREQ   = 20000,
  parameter int LUT_SIZE   = 50,
  parameter int IDX_W      = 6,
  parameter int MAX_RETRY  = 3,
  parameter int AUTO_START = 1
) (
  input  logic             CLOCK_50,
  input  logic             iRST_N,
  input  logic             iSTART,
  output logic [IDX_W-1:0] oLUT_INDEX,
  input  logic [23:0]      iLUT_DATA,
  inout  wire              I2C_SCLK,
  inout  wire              I2C_SDAT,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oERR
);

  localparam int QRAW = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QDIV = (QRAW < 1) ? 1 : QRAW;
  localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  // Index is one bit wider so "index == LUT_SIZE" is reachable even when
  // LUT_SIZE == 2**IDX_W.
  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(LUT_SIZE);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_START, S_SHIFT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t         state, state_n;
  logic [QW-1:0]  qcnt;
  logic [1:0]     qph, qph_n;
  logic [2:0]     bcnt, bcnt_n;
  logic [1:0]     byte_cnt, byte_n;
  logic [23:0]    sr, sr_n;
  logic [IDX_W:0] idx, idx_n;
  logic [3:0]     retry, retry_n;
  logic           nack, nack_n;
  logic           first;
  logic           busy_n, done_n, err_n;
  logic           scl_low, sda_low, scl_low_n, sda_low_n;
  logic           run, freeze, tick;

  assign run = state inside {S_START, S_SHIFT, S_ACK, S_STOP, S_GAP};

`ifdef I2C_CFG_CLK_STRETCH_EN
  // scl_low reflects this quarter's drive, so a low pin while released
  // means a slave is holding the clock.
  assign freeze = run && !scl_low && !I2C_SCLK;
`else
  assign freeze = 1'b0;
`endif

  assign tick = run && !freeze && (qcnt == QW'(QDIV - 1));

  always_comb begin
    state_n = state;   qph_n  = qph;   bcnt_n  = bcnt;  byte_n = byte_cnt;
    sr_n    = sr;      idx_n  = idx;   retry_n = retry; nack_n = nack;
    busy_n  = oBUSY;   done_n = oDONE; err_n   = oERR;
    case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (iSTART || (state == S_IDLE && first && AUTO_START != 0)) begin
          state_n = S_FETCH; idx_n = '0; retry_n = '0;
          busy_n = 1'b1; done_n = 1'b0; err_n = 1'b0;
        end
      S_FETCH: begin
        sr_n = iLUT_DATA; qph_n = '0; bcnt_n = '0; byte_n = '0; nack_n = 1'b0;
        if (iLUT_DATA[23:16] == 8'hFF || idx == LAST) begin
          state_n = S_DONE; busy_n = 1'b0; done_n = 1'b1;
        end else begin
          state_n = S_START;
        end
      end
      S_START, S_STOP:
        if (tick) begin
          if (qph == 2'd2) begin
            state_n = (state == S_START) ? S_SHIFT : S_GAP;
            qph_n   = '0;
          end else begin
            qph_n = qph + 2'd1;
          end
        end
      S_SHIFT:
        if (tick) begin
          qph_n = qph + 2'd1;
          if (qph == 2'd3) begin
            sr_n   = {sr[22:0], 1'b0};
            bcnt_n = bcnt + 3'd1;
            if (bcnt == 3'd7) state_n = S_ACK;
          end
        end
      S_ACK:
        if (tick) begin
          qph_n = qph + 2'd1;
          if (qph == 2'd2) nack_n = I2C_SDAT;
          if (qph == 2'd3) begin
            if (nack || byte_cnt == 2'd2) state_n = S_STOP;
            else begin state_n = S_SHIFT; byte_n = byte_cnt + 2'd1; end
          end
        end
      S_GAP:
        if (tick) begin
          qph_n = qph + 2'd1;
          if (qph == 2'd3) begin
            if (!nack) begin
              idx_n = idx + 1'b1; retry_n = '0; state_n = S_FETCH;
            end else if (retry < 4'(MAX_RETRY)) begin
              retry_n = retry + 4'd1; state_n = S_FETCH;
            end else begin
              state_n = S_ERROR; busy_n = 1'b0; err_n = 1'b1;
            end
          end
        end
      default: state_n = S_IDLE;
    endcase

    // Bus drive is decoded from the next state so the registered pins line
    // up exactly with the state/quarter they belong to.
    scl_low_n = 1'b0;
    sda_low_n = 1'b0;
    case (state_n)
      S_START: begin sda_low_n = (qph_n != 2'd0); scl_low_n = (qph_n == 2'd2); end
      S_SHIFT: begin sda_low_n = !sr_n[23]; scl_low_n = (qph_n == 2'd0) || (qph_n == 2'd3); end
      S_ACK:   scl_low_n = (qph_n == 2'd0) || (qph_n == 2'd3);
      S_STOP:  begin sda_low_n = (qph_n != 2'd2); scl_low_n = (qph_n == 2'd0); end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= S_IDLE; qcnt <= '0; qph <= '0; bcnt <= '0; byte_cnt <= '0;
      sr <= '0; idx <= '0; retry <= '0; nack <= 1'b0; first <= 1'b1;
      oBUSY <= 1'b0; oDONE <= 1'b0; oERR <= 1'b0;
      scl_low <= 1'b0; sda_low <= 1'b0;
    end else begin
      state <= state_n; qph <= qph_n; bcnt <= bcnt_n; byte_cnt <= byte_n;
      sr <= sr_n; idx <= idx_n; retry <= retry_n; nack <= nack_n; first <= 1'b0;
      oBUSY <= busy_n; oDONE <= done_n; oERR <= err_n;
      scl_low <= scl_low_n; sda_low <= sda_low_n;
      if (!run || tick) qcnt <= '0;
      else if (!freeze) qcnt <= qcnt + 1'b1;
    end
  end

  assign oLUT_INDEX = idx[IDX_W-1:0];
  assign I2C_SCLK   = scl_low ? 1'b0 : 1'bz;
  assign I2C_SDAT   = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: QDIV=2, 4-entry table, an I2C slave model that
// ACKs address 8'h34. Expected frames go into a queue when a run is set up
// and are popped as the slave sees each STOP.
module tb_i2c_cfg_sequencer;
  localparam int QDIV      = 2;
  localparam int LUT_SIZE  = 4;
  localparam int IDX_W     = 6;
  localparam int MAX_RETRY = 3;
  localparam int ENTRY_CYC = 1 + 118 * QDIV;

  logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [IDX_W-1:0] lut_index;
  logic [23:0]      lut_data;
  logic             busy, done, err;
  wire              scl, sda;
  logic             slv_scl_low = 1'b0, slv_sda_low = 1'b0;
  logic [23:0]      lut [LUT_SIZE];
  int               cyc = 0;
  int               n_tests = 0, n_fail = 0;

  pullup (scl);
  pullup (sda);
  assign scl = slv_scl_low ? 1'b0 : 1'bz;
  assign sda = slv_sda_low ? 1'b0 : 1'bz;
  assign lut_data = (lut_index < IDX_W'(LUT_SIZE)) ? lut[lut_index[1:0]] : 24'h0;

  i2c_cfg_sequencer #(.CLK_FREQ(800000), .I2C_FREQ(100000), .LUT_SIZE(LUT_SIZE),
                      .IDX_W(IDX_W), .MAX_RETRY(MAX_RETRY), .AUTO_START(1)) dut (
    .CLOCK_50(clk), .iRST_N(rst_n), .iSTART(start), .oLUT_INDEX(lut_index),
    .iLUT_DATA(lut_data), .I2C_SCLK(scl), .I2C_SDAT(sda),
    .oBUSY(busy), .oDONE(done), .oERR(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0][23:0] tbl;
    logic [7:0]       nsub;
    logic [3:0]       ncnt;
    logic [15:0]      exp_cyc;
    logic             exp_done, exp_err;
    logic [IDX_W-1:0] exp_idx;
  } vec_t;

  // slave model state
  logic       prev_scl = 1'b1, prev_sda = 1'b1, in_frame = 1'b0, ack_ph = 1'b0;
  logic [7:0] cur_byte = 8'h0, nack_sub = 8'h0;
  logic [23:0] frame = 24'h0;
  int         bitcnt = 0, nbytes = 0, nack_used = 0, nack_cnt = 0, stretch_cnt = 0;
  logic       stretch_en = 1'b0, stretch_done = 1'b0;
  logic [25:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_frame();
    logic [25:0] got;
    got = {2'(nbytes), frame};
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL frame: unexpected frame 0x%0h, none expected", got);
    end else begin
      check("frame", 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic slave_step();
    logic s_scl, s_sda, ack;
    s_scl = scl; s_sda = sda;
    if (!rst_n) begin
      in_frame = 1'b0; ack_ph = 1'b0; slv_sda_low = 1'b0; slv_scl_low = 1'b0;
      stretch_cnt = 0; stretch_done = 1'b0; nack_used = 0;
    end else begin
      if (stretch_cnt > 0) begin
        stretch_cnt--;
        if (stretch_cnt == 0) slv_scl_low = 1'b0;
      end
      if (prev_scl && s_scl && prev_sda && !s_sda) begin
        in_frame = 1'b1; ack_ph = 1'b0; bitcnt = 0; nbytes = 0; frame = 24'h0;
      end else if (prev_scl && s_scl && !prev_sda && s_sda && in_frame) begin
        in_frame = 1'b0;
        sb_frame();
      end else if (in_frame && !prev_scl && s_scl && bitcnt < 8) begin
        cur_byte = {cur_byte[6:0], s_sda}; bitcnt++;
      end else if (in_frame && prev_scl && !s_scl) begin
        if (ack_ph) begin
          ack_ph = 1'b0; bitcnt = 0; slv_sda_low = 1'b0;
        end else if (bitcnt == 8) begin
          frame = frame | ({cur_byte, 16'h0} >> (8 * nbytes));
          if (nbytes == 0) ack = (cur_byte == 8'h34);
          else if (nbytes == 1 && cur_byte == nack_sub && nack_used < nack_cnt) begin
            ack = 1'b0; nack_used++;
          end else ack = 1'b1;
          slv_sda_low = ack; ack_ph = 1'b1;
          // This fall starts q3 of bit 7: hold through it and ACK q0, then
          // 10 more cycles into the released quarter.
          if (stretch_en && nbytes == 0 && !stretch_done) begin
            slv_scl_low = 1'b1; stretch_cnt = 2 * QDIV + 10; stretch_done = 1'b1;
          end
          nbytes++;
        end
      end
    end
    prev_scl = s_scl; prev_sda = s_sda;
  endtask

  task automatic tick();
    @(negedge clk);
    slave_step();
  endtask

  task automatic wait_busy(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (busy) begin t = cyc; break; end
    end
    if (t < 0) begin n_tests++; n_fail++; $display("FAIL busy_rise: not seen in %0d cycles", budget); end
  endtask

  task automatic wait_end(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done || err) begin t = cyc; break; end
    end
    if (t < 0) begin n_tests++; n_fail++; $display("FAIL end: no done/err in %0d cycles", budget); end
  endtask

  // Reference frame list: {byte count, bytes left-aligned}.
  task automatic push_expected(input vec_t v);
    logic [7:0] a;
    exp_q.delete();
    for (int e = 0; e < LUT_SIZE; e++) begin
      a = v.tbl[e][23:16];
      if (a == 8'hFF) break;
      if (a != 8'h34) begin
        for (int r = 0; r <= MAX_RETRY; r++) exp_q.push_back({2'd1, a, 16'h0});
        break;
      end
      if (v.tbl[e][15:8] == v.nsub)
        for (int r = 0; r < int'(v.ncnt); r++) exp_q.push_back({2'd2, v.tbl[e][23:8], 8'h0});
      exp_q.push_back({2'd3, v.tbl[e]});
    end
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < LUT_SIZE; i++) lut[i] = v.tbl[i];
    nack_sub = v.nsub; nack_cnt = int'(v.ncnt);
    push_expected(v);
  endtask

  task automatic run_vec(input vec_t v);
    int t0, t1;
    rst_n = 1'b0;
    load(v);
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err",  32'(err), 0);
    check("rst_idx",  32'(lut_index), 0);
    check("rst_scl",  32'(scl), 1);
    check("rst_sda",  32'(sda), 1);
    rst_n = 1'b1;
    wait_busy(10, t0);
    wait_end(4000, t1);
    if (t0 >= 0 && t1 >= 0) check("cycles", 32'(t1 - t0), 32'(v.exp_cyc));
    check("done", 32'(done), 32'(v.exp_done));
    check("err",  32'(err), 32'(v.exp_err));
    check("busy_end", 32'(busy), 0);
    check("idx_end", 32'(lut_index), 32'(v.exp_idx));
    repeat (6) tick();
    check("sb_left", 32'(exp_q.size()), 0);
  endtask

  function automatic vec_t mk(input logic [3:0][23:0] tbl, input logic [7:0] nsub,
                              input logic [3:0] ncnt, input int c, input logic d,
                              input logic e, input int idx);
    vec_t v;
    v.tbl = tbl; v.nsub = nsub; v.ncnt = ncnt; v.exp_cyc = 16'(c);
    v.exp_done = d; v.exp_err = e; v.exp_idx = IDX_W'(idx);
    return v;
  endfunction

  localparam logic [3:0][23:0] T_NORM = {24'h34074D, 24'h340901, 24'h340279, 24'h340018};
  localparam logic [3:0][23:0] T_BAD2 = {24'h34074D, 24'h360901, 24'h340279, 24'h340018};
  localparam logic [3:0][23:0] T_END1 = {24'h34074D, 24'h340901, 24'hFF1234, 24'h340018};

  initial begin
    vec_t vecs [4];
    int t0, t1, k;
    // busy-rise to done/err-rise edge counts
    vecs[0] = mk(T_NORM, 8'h00, 4'd0, 4 * ENTRY_CYC + 1, 1'b1, 1'b0, 4);
    vecs[1] = mk(T_NORM, 8'h02, 4'd2, 4 * ENTRY_CYC + 2 * (1 + 82 * QDIV) + 1, 1'b1, 1'b0, 4);
    vecs[2] = mk(T_BAD2, 8'h00, 4'd0, 2 * ENTRY_CYC + 4 * (1 + 46 * QDIV), 1'b0, 1'b1, 2);
    vecs[3] = mk(T_END1, 8'h00, 4'd0, ENTRY_CYC + 1, 1'b1, 1'b0, 1);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Re-trigger from DONE; a second start while busy must be ignored.
    load(vecs[0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_busy", 32'(busy), 1);
    check("restart_done_clr", 32'(done), 0);
    t0 = cyc;
    repeat (300) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_end(4000, t1);
    if (t1 >= 0) check("restart_cycles", 32'(t1 - t0), 32'(4 * ENTRY_CYC + 1));
    check("restart_done", 32'(done), 1);
    repeat (6) tick();
    check("restart_sb_left", 32'(exp_q.size()), 0);

    // Reset in bit 5 of the second byte: bus released at once, clean restart.
    rst_n = 1'b0;
    load(vecs[0]);
    repeat (3) tick();
    rst_n = 1'b1;
    k = 0;
    while (!(in_frame && nbytes == 1 && !ack_ph && bitcnt == 6) && k < 600) begin
      tick(); k++;
    end
    check("midbyte_reached", 32'(k < 600), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_scl", 32'(scl), 1);
    check("midrst_sda", 32'(sda), 1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_idx", 32'(lut_index), 0);
    load(vecs[0]);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_busy(10, t0);
    wait_end(4000, t1);
    if (t0 >= 0 && t1 >= 0) check("midrst_cycles", 32'(t1 - t0), 32'(4 * ENTRY_CYC + 1));
    check("midrst_done", 32'(done), 1);
    repeat (6) tick();
    check("midrst_sb_left", 32'(exp_q.size()), 0);

`ifdef I2C_CFG_CLK_STRETCH_EN
    // Slave stretches SCL for 10 cycles during the ACK of byte 0.
    stretch_en = 1'b1;
    run_vec(mk(T_NORM, 8'h00, 4'd0, 4 * ENTRY_CYC + 1 + 10, 1'b1, 1'b0, 4));
    stretch_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
